// File: rtl/int_ctrl.sv
// int_ctrl: memory-mapped interrupt controller sitting between peripheral
// interrupt lines and the CPU HWInt[7:2] inputs.
//
// Each raw source is synchronised, latched as edge- or level-triggered,
// masked per source, and presented to CP0 as a registered request vector.
// Software configures and acknowledges sources through a 4-word window
// on the CPU bridge bus.
//
// Ports:
//   clk      in   1       system clock, all state on the rising edge
//   reset    in   1       asynchronous, active-low clear of all state
//   irq_src  in   N_SRC   raw asynchronous interrupt lines
//   PrAddr   in   30      bridge word address [31:2]
//   PrWD     in   32      bridge write data
//   PrWe     in   1       bridge write strobe
//   PrRD     out  32      read data, combinational from PrAddr and registers
//   HWInt    out  6       registered request to CP0, HWInt[i+2] = source i
//
// Register window (byte offsets from BASE_ADDR):
//   +0x0 ENABLE  RW
//   +0x4 MODE    RW   1 = edge, 0 = level
//   +0x8 PENDING RW1C (write-one-clear only affects edge-mode bits)
//   +0xC STATUS  RO   {valid, 28'b0, idx[2:0]}
//
// Bus protocol: there is no valid/ready pair. A write is accepted on every
// rising edge where PrWe=1 and the address hits the window; the bridge
// never stalls. Reads are purely combinational and side-effect free.

module int_ctrl #(
  parameter int          N_SRC       = 6,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_7F20,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [31:2]      PrAddr,
  input  logic [31:0]      PrWD,
  input  logic             PrWe,
  output logic [31:0]      PrRD,
  output logic [7:2]       HWInt
);

  // State
  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q;
  logic [N_SRC-1:0] s_prev_q;
  logic [N_SRC-1:0] en_q, en_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [5:0]       hw_q, hw_d;

  // Decode
  logic             hit;
  logic [1:0]       sel;
  logic             we_en, we_mode, we_pend;
  logic [N_SRC-1:0] s, rise, w1c, mode_chg, active;
  logic             st_valid;
  logic [2:0]       st_idx;

  // Write data above the implemented source bits is deliberately dropped.
  logic unused_wd;
  assign unused_wd = ^PrWD[31:N_SRC];

  assign s   = sync_q[SYNC_STAGES-1];
  assign hit = (PrAddr[31:4] == BASE_ADDR[31:4]);
  assign sel = PrAddr[3:2];

  assign we_en   = PrWe && hit && (sel == 2'd0);
  assign we_mode = PrWe && hit && (sel == 2'd1);
  assign we_pend = PrWe && hit && (sel == 2'd2);

  assign rise     = s & ~s_prev_q;
  assign w1c      = {N_SRC{we_pend}} & PrWD[N_SRC-1:0];
  assign en_d     = we_en   ? PrWD[N_SRC-1:0] : en_q;
  assign mode_d   = we_mode ? PrWD[N_SRC-1:0] : mode_q;
  assign mode_chg = mode_d ^ mode_q;

  // Everything is evaluated under the new mode, so a bit whose mode is being
  // switched starts from zero and is only set by an edge/level seen now.
  // In edge mode a fresh edge beats a same-cycle W1C. Level bits simply
  // follow the synchronised input, which also makes W1C a no-op for them.
  assign pend_d = (mode_d & (rise | (pend_q & ~w1c & ~mode_chg)))
                | (~mode_d & s);

  assign active = pend_q & en_q;

  always_comb begin
    hw_d = '0;
    hw_d[N_SRC-1:0] = active;
  end

  // Lowest active source wins: scan from the top so lower indices overwrite.
  always_comb begin
    st_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) st_idx = 3'(i);
    end
  end
  assign st_valid = |active;

  always_comb begin
    PrRD = '0;
    if (hit) begin
      case (sel)
        2'd0:    PrRD[N_SRC-1:0] = en_q;
        2'd1:    PrRD[N_SRC-1:0] = mode_q;
        2'd2:    PrRD[N_SRC-1:0] = pend_q;
        default: PrRD = {st_valid, 28'b0, st_idx};
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      s_prev_q <= '0;
      en_q     <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      hw_q     <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_src};
      s_prev_q <= s;
      en_q     <= en_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      hw_q     <= hw_d;
    end
  end

  assign HWInt = hw_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed testbench for int_ctrl with default parameters
// (N_SRC=6, BASE_ADDR=0x7F20, SYNC_STAGES=2).

`timescale 1ns/1ps

module tb_int_ctrl;

  localparam logic [31:0] BASE     = 32'h0000_7F20;
  localparam logic [2:0]  OFF_EN   = 3'd0;
  localparam logic [2:0]  OFF_MODE = 3'd1;
  localparam logic [2:0]  OFF_PEND = 3'd2;
  localparam logic [2:0]  OFF_STAT = 3'd3;
  localparam logic [2:0]  OFF_MISS = 3'd4;

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_src;
  logic [31:2] PrAddr;
  logic [31:0] PrWD;
  logic        PrWe;
  logic [31:0] PrRD;
  logic [7:2]  HWInt;

  logic [31:2] base_w;
  int          n_vec = 0;
  int          n_mis = 0;

  always #10 clk = ~clk;

  int_ctrl #(
    .N_SRC      (6),
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .irq_src(irq_src),
    .PrAddr (PrAddr),
    .PrWD   (PrWD),
    .PrWe   (PrWe),
    .PrRD   (PrRD),
    .HWInt  (HWInt)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    PrAddr = base_w + {27'd0, off};
    PrWD   = d;
    PrWe   = 1'b1;
    step();
    PrWe   = 1'b0;
    PrWD   = '0;
  endtask

  // Checkers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    PrAddr = base_w + {27'd0, off};
    #1;
    chk(tag, PrRD, exp);
  endtask

  task automatic chk_hw(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, HWInt}, {26'd0, exp});
  endtask

  initial begin
    base_w  = BASE[31:2];
    reset   = 1'b0;
    irq_src = '0;
    PrAddr  = base_w;
    PrWD    = '0;
    PrWe    = 1'b0;

    // T1: reset holds everything at zero even with all sources active
    repeat (2) step();
    irq_src = 6'h3F;
    repeat (4) step();
    chk_hw("t1_hwint", 6'h00);
    chk_rd("t1_rd_enable",  OFF_EN,   32'h0);
    chk_rd("t1_rd_mode",    OFF_MODE, 32'h0);
    chk_rd("t1_rd_pending", OFF_PEND, 32'h0);
    chk_rd("t1_rd_status",  OFF_STAT, 32'h0);
    irq_src = '0;
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();

    // T2: edge source 0, latency and W1C
    wr(OFF_EN, 32'h1);
    wr(OFF_MODE, 32'h1);
    irq_src = 6'h01;
    repeat (3) step();
    chk_hw("t2_hw_before", 6'h00);
    chk_rd("t2_pend_set", OFF_PEND, 32'h1);
    step();
    chk_hw("t2_hw_set", 6'h01);
    chk_rd("t2_status", OFF_STAT, 32'h8000_0000);
    wr(OFF_PEND, 32'h1);
    chk_hw("t2_hw_after_w1c_1", 6'h01);
    chk_rd("t2_pend_cleared", OFF_PEND, 32'h0);
    step();
    chk_hw("t2_hw_after_w1c_2", 6'h00);
    repeat (3) step();
    chk_rd("t2_hold_no_reset", OFF_PEND, 32'h0);
    chk_hw("t2_hw_hold", 6'h00);
    irq_src = '0;
    repeat (4) step();
    chk_rd("t2_fall_no_set", OFF_PEND, 32'h0);

    // T3: level source 3, W1C ignored, follows input
    wr(OFF_MODE, 32'h0);
    wr(OFF_EN, 32'h08);
    irq_src = 6'h08;
    repeat (4) step();
    chk_hw("t3_hw_set", 6'h08);
    chk_rd("t3_status", OFF_STAT, 32'h8000_0003);
    wr(OFF_PEND, 32'h08);
    chk_rd("t3_w1c_ignored", OFF_PEND, 32'h08);
    step();
    chk_hw("t3_hw_still", 6'h08);
    irq_src = '0;
    repeat (3) step();
    chk_hw("t3_hw_late", 6'h08);
    step();
    chk_hw("t3_hw_drop", 6'h00);

    // T4: masking with edges on sources 1 and 4
    wr(OFF_EN, 32'h0);
    wr(OFF_MODE, 32'h3F);
    irq_src = 6'h12;
    repeat (4) step();
    chk_rd("t4_pending", OFF_PEND, 32'h12);
    chk_hw("t4_hw_masked", 6'h00);
    chk_rd("t4_status_masked", OFF_STAT, 32'h0);
    wr(OFF_EN, 32'h10);
    chk_hw("t4_hw_not_yet", 6'h00);
    chk_rd("t4_status_idx4", OFF_STAT, 32'h8000_0004);
    step();
    chk_hw("t4_hw_src4", 6'h10);
    irq_src = '0;

    // T5: new edge on source 2 collides with W1C of bit 2
    wr(OFF_PEND, 32'h3F);
    chk_rd("t5_cleared", OFF_PEND, 32'h0);
    irq_src = 6'h04;
    repeat (2) step();
    wr(OFF_PEND, 32'h04);
    chk_rd("t5_collision", OFF_PEND, 32'h04);
    wr(OFF_PEND, 32'h04);
    chk_rd("t5_w1c_plain", OFF_PEND, 32'h0);
    irq_src = '0;

    // T6: decode of STATUS writes and out-of-window writes
    wr(OFF_STAT, 32'hFFFF_FFFF);
    wr(OFF_MISS, 32'hFFFF_FFFF);
    chk_rd("t6_enable_kept", OFF_EN,   32'h10);
    chk_rd("t6_mode_kept",   OFF_MODE, 32'h3F);
    chk_rd("t6_pend_kept",   OFF_PEND, 32'h0);
    chk_rd("t6_miss_read",   OFF_MISS, 32'h0);
    wr(OFF_EN, 32'hFFFF_FFFF);
    chk_rd("t6_enable_all", OFF_EN, 32'h3F);

    // T7: asynchronous reset while a request is active
    irq_src = 6'h01;
    repeat (4) step();
    chk_hw("t7_hw_active", 6'h01);
    #2;
    reset = 1'b0;
    #1;
    chk_hw("t7_hw_reset", 6'h00);
    chk_rd("t7_pend_reset", OFF_PEND, 32'h0);
    chk_rd("t7_en_reset",   OFF_EN,   32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
